// File: rtl/pipelined_control_unit.sv
// Control unit for a 5-stage RV32I pipeline: decodes OP/funct3/funct7 in Decode
// and carries the controls through the D/E, E/M and M/W registers.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W     = 3,
  parameter bit STICKY_ILLEGAL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [6:0]            OP,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic                  ZeroE,
  input  logic                  FlushE,
  output logic [1:0]            ImmSrcD,
  output logic                  PCSrcE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  MemWriteM,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic                  ResultSrcE0,
  output logic [1:0]            ResultSrcW,
  output logic                  IllegalOp
);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);

  // Decode-stage controls
  logic                  reg_write_dec, alu_src_dec, mem_write_dec;
  logic                  branch_dec, jump_dec;
  logic [1:0]            imm_src_dec, result_src_dec, alu_op_dec;
  logic [ALU_CTRL_W-1:0] alu_ctrl_dec;
  logic                  op_illegal, funct_illegal, illegal_dec;

  // Pipeline registers
  logic                  reg_write_e_d, reg_write_e_q;
  logic [1:0]            result_src_e_d, result_src_e_q;
  logic                  mem_write_e_d, mem_write_e_q;
  logic                  jump_e_d, jump_e_q;
  logic                  branch_e_d, branch_e_q;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e_d, alu_ctrl_e_q;
  logic                  alu_src_e_d, alu_src_e_q;
  logic                  reg_write_m_d, reg_write_m_q;
  logic [1:0]            result_src_m_d, result_src_m_q;
  logic                  mem_write_m_d, mem_write_m_q;
  logic                  reg_write_w_d, reg_write_w_q;
  logic [1:0]            result_src_w_d, result_src_w_q;
  logic                  illegal_op_d, illegal_op_q;

  always_comb begin
    reg_write_dec  = 1'b0;
    imm_src_dec    = 2'b00;
    alu_src_dec    = 1'b0;
    mem_write_dec  = 1'b0;
    result_src_dec = 2'b00;
    branch_dec     = 1'b0;
    jump_dec       = 1'b0;
    alu_op_dec     = 2'b00;
    op_illegal     = 1'b0;
    case (OP)
      7'b0000011: begin
        reg_write_dec  = 1'b1;
        alu_src_dec    = 1'b1;
        result_src_dec = 2'b01;
      end
      7'b0100011: begin
        imm_src_dec   = 2'b01;
        alu_src_dec   = 1'b1;
        mem_write_dec = 1'b1;
      end
      7'b0110011: begin
        reg_write_dec = 1'b1;
        alu_op_dec    = 2'b10;
      end
      7'b1100011: begin
        imm_src_dec = 2'b10;
        branch_dec  = 1'b1;
        alu_op_dec  = 2'b01;
      end
      7'b0010011: begin
        reg_write_dec = 1'b1;
        alu_src_dec   = 1'b1;
        alu_op_dec    = 2'b10;
      end
      7'b1101111: begin
        reg_write_dec  = 1'b1;
        imm_src_dec    = 2'b11;
        result_src_dec = 2'b10;
        jump_dec       = 1'b1;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_ctrl_dec  = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op_dec)
      2'b01: alu_ctrl_dec = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl_dec = (OP[5] & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_dec = ALU_SLT;
          3'b110:  alu_ctrl_dec = ALU_OR;
          3'b111:  alu_ctrl_dec = ALU_AND;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl_dec = ALU_ADD;
    endcase
  end

  assign illegal_dec = op_illegal | funct_illegal;

  always_comb begin
    reg_write_e_d  = 1'b0;
    result_src_e_d = 2'b00;
    mem_write_e_d  = 1'b0;
    jump_e_d       = 1'b0;
    branch_e_d     = 1'b0;
    alu_ctrl_e_d   = ALU_ADD;
    alu_src_e_d    = 1'b0;
    if (!FlushE) begin
      reg_write_e_d  = reg_write_dec;
      result_src_e_d = result_src_dec;
      mem_write_e_d  = mem_write_dec;
      jump_e_d       = jump_dec;
      branch_e_d     = branch_dec;
      alu_ctrl_e_d   = alu_ctrl_dec;
      alu_src_e_d    = alu_src_dec;
    end
    reg_write_m_d  = reg_write_e_q;
    result_src_m_d = result_src_e_q;
    mem_write_m_d  = mem_write_e_q;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
    // A flushed illegal instruction never retires, so it must not latch the flag
    if (STICKY_ILLEGAL) illegal_op_d = illegal_op_q | (illegal_dec & ~FlushE);
    else                illegal_op_d = illegal_dec;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      reg_write_e_q  <= 1'b0;
      result_src_e_q <= 2'b00;
      mem_write_e_q  <= 1'b0;
      jump_e_q       <= 1'b0;
      branch_e_q     <= 1'b0;
      alu_ctrl_e_q   <= ALU_ADD;
      alu_src_e_q    <= 1'b0;
      reg_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      mem_write_m_q  <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      illegal_op_q   <= 1'b0;
    end else begin
      reg_write_e_q  <= reg_write_e_d;
      result_src_e_q <= result_src_e_d;
      mem_write_e_q  <= mem_write_e_d;
      jump_e_q       <= jump_e_d;
      branch_e_q     <= branch_e_d;
      alu_ctrl_e_q   <= alu_ctrl_e_d;
      alu_src_e_q    <= alu_src_e_d;
      reg_write_m_q  <= reg_write_m_d;
      result_src_m_q <= result_src_m_d;
      mem_write_m_q  <= mem_write_m_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

  assign ImmSrcD     = imm_src_dec;
  assign PCSrcE      = (branch_e_q & ZeroE) | jump_e_q;
  assign ALUSrcE     = alu_src_e_q;
  assign ALUControlE = alu_ctrl_e_q;
  assign MemWriteM   = mem_write_m_q;
  assign RegWriteM   = reg_write_m_q;
  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcE0 = result_src_e_q[0];
  assign ResultSrcW  = result_src_w_q;
  assign IllegalOp   = illegal_op_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: table of decode vectors with expected
// controls, tracked through a per-stage scoreboard queue, plus reset sequences.
module tb_pipelined_control_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [6:0] OP = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       ZeroE = 1'b0;
  logic       FlushE = 1'b0;
  logic [1:0] ImmSrcD;
  logic       PCSrcE, ALUSrcE, MemWriteM, RegWriteM, RegWriteW, ResultSrcE0, IllegalOp;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcW;

  pipelined_control_unit dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .funct3(funct3), .funct7(funct7),
    .ZeroE(ZeroE), .FlushE(FlushE), .ImmSrcD(ImmSrcD), .PCSrcE(PCSrcE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .ResultSrcW(ResultSrcW), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic zero; logic flush;
    logic [1:0] imm; logic alusrc; logic [2:0] aluctrl; logic regw;
    logic [1:0] ressrc; logic memw; logic br; logic jmp; logic ill;
  } vec_t;

  typedef struct {
    logic alusrc; logic [2:0] aluctrl; logic regw; logic [1:0] ressrc;
    logic memw; logic br; logic jmp; logic zero;
  } stage_t;

  vec_t   vecs[$];
  stage_t sb[$];
  int     checks = 0;
  int     failures = 0;
  logic   ill_model = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stage_t bubble();
    stage_t s;
    s = '{alusrc: 1'b0, aluctrl: 3'b000, regw: 1'b0, ressrc: 2'b00,
          memw: 1'b0, br: 1'b0, jmp: 1'b0, zero: 1'b0};
    return s;
  endfunction

  task automatic sb_clear();
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(bubble());
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic zero, input logic flush, input logic [1:0] imm,
                         input logic alusrc, input logic [2:0] aluctrl, input logic regw,
                         input logic [1:0] ressrc, input logic memw, input logic br,
                         input logic jmp, input logic ill);
    vec_t v;
    v = '{op: op, f3: f3, f7: f7, zero: zero, flush: flush, imm: imm, alusrc: alusrc,
          aluctrl: aluctrl, regw: regw, ressrc: ressrc, memw: memw, br: br, jmp: jmp, ill: ill};
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input string tag);
    stage_t s;
    stage_t e;
    @(negedge CLK);
    OP = v.op; funct3 = v.f3; funct7 = v.f7; FlushE = v.flush;
    e = sb[$];
    ZeroE = e.zero;
    #1;
    chk({tag, ".ImmSrcD"}, 8'(ImmSrcD), 8'(v.imm));
    chk({tag, ".PCSrcE"}, 8'(PCSrcE), 8'((e.br & e.zero) | e.jmp));
    @(posedge CLK);
    if (v.flush) s = bubble();
    else s = '{alusrc: v.alusrc, aluctrl: v.aluctrl, regw: v.regw, ressrc: v.ressrc,
               memw: v.memw, br: v.br, jmp: v.jmp, zero: v.zero};
    sb.push_back(s);
    if (v.ill && !v.flush) ill_model = 1'b1;
    #1;
    chk({tag, ".ALUSrcE"}, 8'(ALUSrcE), 8'(sb[$].alusrc));
    chk({tag, ".ALUControlE"}, 8'(ALUControlE), 8'(sb[$].aluctrl));
    chk({tag, ".ResultSrcE0"}, 8'(ResultSrcE0), 8'(sb[$].ressrc[0]));
    chk({tag, ".MemWriteM"}, 8'(MemWriteM), 8'(sb[$-1].memw));
    chk({tag, ".RegWriteM"}, 8'(RegWriteM), 8'(sb[$-1].regw));
    chk({tag, ".RegWriteW"}, 8'(RegWriteW), 8'(sb[$-2].regw));
    chk({tag, ".ResultSrcW"}, 8'(ResultSrcW), 8'(sb[$-2].ressrc));
    chk({tag, ".IllegalOp"}, 8'(IllegalOp), 8'(ill_model));
    while (sb.size() > 3) void'(sb.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".PCSrcE"}, 8'(PCSrcE), 8'h0);
    chk({tag, ".ALUSrcE"}, 8'(ALUSrcE), 8'h0);
    chk({tag, ".ALUControlE"}, 8'(ALUControlE), 8'h0);
    chk({tag, ".MemWriteM"}, 8'(MemWriteM), 8'h0);
    chk({tag, ".RegWriteM"}, 8'(RegWriteM), 8'h0);
    chk({tag, ".RegWriteW"}, 8'(RegWriteW), 8'h0);
    chk({tag, ".ResultSrcE0"}, 8'(ResultSrcE0), 8'h0);
    chk({tag, ".ResultSrcW"}, 8'(ResultSrcW), 8'h0);
    chk({tag, ".IllegalOp"}, 8'(IllegalOp), 8'h0);
  endtask

  initial begin
    //       op          f3      f7 z  fl imm   as ctrl    rw rs     mw br j  ill
    add_vec(7'b0000011, 3'b010, 0, 0, 0, 2'b00, 1, 3'b000, 1, 2'b01, 0, 0, 0, 0); // lw
    add_vec(7'b0110011, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 1, 2'b00, 0, 0, 0, 0); // add
    add_vec(7'b0110011, 3'b000, 1, 0, 0, 2'b00, 0, 3'b001, 1, 2'b00, 0, 0, 0, 0); // sub
    add_vec(7'b0010011, 3'b000, 1, 0, 0, 2'b00, 1, 3'b000, 1, 2'b00, 0, 0, 0, 0); // addi, f7=1
    add_vec(7'b0110011, 3'b010, 0, 0, 0, 2'b00, 0, 3'b101, 1, 2'b00, 0, 0, 0, 0); // slt
    add_vec(7'b0010011, 3'b110, 0, 0, 0, 2'b00, 1, 3'b011, 1, 2'b00, 0, 0, 0, 0); // ori
    add_vec(7'b0110011, 3'b111, 0, 0, 0, 2'b00, 0, 3'b010, 1, 2'b00, 0, 0, 0, 0); // and
    add_vec(7'b0100011, 3'b010, 0, 0, 0, 2'b01, 1, 3'b000, 0, 2'b00, 1, 0, 0, 0); // sw
    add_vec(7'b1100011, 3'b000, 0, 1, 0, 2'b10, 0, 3'b001, 0, 2'b00, 0, 1, 0, 0); // beq taken
    add_vec(7'b1100011, 3'b000, 0, 0, 0, 2'b10, 0, 3'b001, 0, 2'b00, 0, 1, 0, 0); // beq not taken
    add_vec(7'b1101111, 3'b101, 1, 0, 0, 2'b11, 0, 3'b000, 1, 2'b10, 0, 0, 1, 0); // jal, zero=0
    add_vec(7'b1101111, 3'b000, 0, 1, 0, 2'b11, 0, 3'b000, 1, 2'b10, 0, 0, 1, 0); // jal, zero=1
    add_vec(7'b1100011, 3'b000, 0, 1, 0, 2'b10, 0, 3'b001, 0, 2'b00, 0, 1, 0, 0); // beq taken
    add_vec(7'b0100011, 3'b010, 0, 0, 1, 2'b01, 1, 3'b000, 0, 2'b00, 1, 0, 0, 0); // sw flushed
    add_vec(7'b0000011, 3'b010, 0, 0, 1, 2'b00, 1, 3'b000, 1, 2'b01, 0, 0, 0, 0); // lw flushed
    add_vec(7'b0010011, 3'b111, 0, 0, 0, 2'b00, 1, 3'b010, 1, 2'b00, 0, 0, 0, 0); // andi
    add_vec(7'b1111111, 3'b000, 0, 0, 1, 2'b00, 0, 3'b000, 0, 2'b00, 0, 0, 0, 1); // illegal flushed
    add_vec(7'b0010011, 3'b000, 0, 0, 0, 2'b00, 1, 3'b000, 1, 2'b00, 0, 0, 0, 0); // addi
    add_vec(7'b1111111, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 0, 2'b00, 0, 0, 0, 1); // illegal op
    add_vec(7'b0110011, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 1, 2'b00, 0, 0, 0, 0); // add
    add_vec(7'b0110011, 3'b001, 0, 0, 0, 2'b00, 0, 3'b000, 1, 2'b00, 0, 0, 0, 1); // sll: illegal funct3
    add_vec(7'b0000011, 3'b010, 0, 0, 0, 2'b00, 1, 3'b000, 1, 2'b01, 0, 0, 0, 0); // lw
    add_vec(7'b0110011, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 1, 2'b00, 0, 0, 0, 0); // add
    add_vec(7'b0110011, 3'b000, 0, 0, 0, 2'b00, 0, 3'b000, 1, 2'b00, 0, 0, 0, 0); // add

    // Reset held with an R-type in Decode and FlushE high
    RESET = 1'b0; FlushE = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("rst_hold");
    chk("rst_hold.ImmSrcD", 8'(ImmSrcD), 8'h0);
    OP = 7'b1101111;
    #1;
    chk("rst_hold.ImmSrcD_follow", 8'(ImmSrcD), 8'h3);
    OP = 7'b0110011;
    @(negedge CLK);
    RESET = 1'b1; FlushE = 1'b0;
    @(posedge CLK); #1;
    chk("rst_rel.ALUControlE", 8'(ALUControlE), 8'h0);
    chk("rst_rel.ALUSrcE", 8'(ALUSrcE), 8'h0);

    sb_clear();
    sb.push_back('{alusrc: 1'b0, aluctrl: 3'b000, regw: 1'b1, ressrc: 2'b00,
                   memw: 1'b0, br: 1'b0, jmp: 1'b0, zero: 1'b0});
    void'(sb.pop_front());
    ill_model = 1'b0;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Reset mid-flight: lw/sw/jal in the pipe, then async reset between edges
    step(vecs[0], "pre_rst_lw");
    step(vecs[7], "pre_rst_sw");
    step(vecs[10], "pre_rst_jal");
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge CLK);
    OP = 7'b0010011; funct3 = 3'b000; funct7 = 1'b0; FlushE = 1'b1;
    RESET = 1'b1;
    sb_clear();
    ill_model = 1'b0;
    for (int i = 0; i < 3; i++) step(vecs[14], $sformatf("post_rst%0d", i));
    step(vecs[1], "post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Control unit for the 5-stage RV32I pipeline. It decodes the instruction in Decode from the OP/funct3/funct7 fields that the datapath exports, and drives every control input the datapath consumes. It carries decoded controls through its own D/E, E/M and M/W pipeline registers. It also resolves branch/jump redirection in Execute from ZeroE.

Parameters:
ALU_CTRL_W, 3, width of ALUControlE.
STICKY_ILLEGAL, 1, 1 = IllegalOp stays latched until reset; 0 = IllegalOp is a one-cycle pulse per illegal Decode instruction.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset.
OP  input  7  InstrD[6:0].
funct3  input  3  InstrD[14:12].
funct7  input  1  InstrD[30].
ZeroE  input  1  ALU zero flag, Execute stage, combinational from datapath.
FlushE  input  1  from hazard unit; turns the instruction entering Execute into a bubble.
ImmSrcD  output  2  immediate format, combinational from Decode.
PCSrcE  output  1  redirect PC to PCTargetE.
ALUSrcE  output  1  0 = RD2E, 1 = ImmExtE.
ALUControlE  output  3  ALU operation.
MemWriteM  output  1  data memory write enable.
RegWriteM  output  1  to hazard unit for forwarding.
RegWriteW  output  1  register file write enable.
ResultSrcE0  output  1  ResultSrcE[0], to hazard unit for load-use detection.
ResultSrcW  output  2  writeback mux select.
IllegalOp  output  1  unsupported opcode seen in Decode.

Behaviour:
- Main decode (Decode stage, combinational). Each entry gives RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp:
  - lw 0000011: 1, 00, 1, 0, 01, 0, 0, 00.
  - sw 0100011: 0, 01, 1, 1, xx→00, 0, 0, 00.
  - R-type 0110011: 1, xx→00, 0, 0, 00, 0, 0, 10.
  - beq 1100011: 0, 10, 0, 0, 00, 1, 0, 01.
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 0, 10.
  - jal 1101111: 1, 11, x→0, 0, 10, 0, 1, 00.
- Any other OP decodes to all-zero controls (no register write, no memory write, no branch) and asserts illegal in Decode.
- Don't-care fields are driven to 0. No X is ever propagated.
- ALU decode, ALUControl values: add 000, sub 001, and 010, or 011, slt 101.
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 with funct3 000 → sub if (OP[5] & funct7), otherwise add.
  - ALUOp 10 with funct3 010 → slt; 110 → or; 111 → and.
  - ALUOp 10 with any other funct3 → add, and asserts illegal.
- D/E register holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl and ALUSrc.
  - FlushE = 1 at the edge loads all zeros (a bubble).
- E/M register holds RegWrite, ResultSrc, MemWrite. M/W register holds RegWrite, ResultSrc. Both always advance; there is no stall input.
- Latency from Decode fields:
  - ALUSrcE, ALUControlE: 1 cycle.
  - MemWriteM, RegWriteM: 2 cycles.
  - RegWriteW, ResultSrcW: 3 cycles.
- PCSrcE = (BranchE & ZeroE) | JumpE, combinational in Execute. A flushed (bubble) slot always gives PCSrcE = 0.
- IllegalOp:
  - STICKY_ILLEGAL = 1: registered; set at the edge where a Decode instruction is illegal and FlushE is not asserted; cleared only by reset.
  - STICKY_ILLEGAL = 0: registered pulse one cycle after the illegal Decode instruction.
- Reset (RESET = 0): asynchronously clears every pipeline register and IllegalOp. Consequences:
  - All registered outputs read 0 and PCSrcE = 0 immediately.
  - ImmSrcD continues to follow OP.
  - Reset asserted mid-instruction discards all in-flight controls; no partial write may leak.
- Reset dominates FlushE.
- A FlushE coinciding with a taken branch in Execute still lets the branch's own PCSrcE act in that cycle.

Test Plan:
- Reset: hold RESET = 0 with OP = 0110011 → all registered outputs and PCSrcE = 0. Release; next edge → ALUControlE = 000, ALUSrcE = 0.
- Pipeline timing: issue lw (OP 0000011) at cycle 0 → ALUSrcE = 1 at cycle 1, RegWriteM = 1 at cycle 2, ResultSrcW = 01 and RegWriteW = 1 at cycle 3, ImmSrcD = 00 at cycle 0.
- R-type sub (OP 0110011, funct3 000, funct7 1) → ALUControlE = 001. The same fields with OP 0010011 (addi) → 000.
- beq with ZeroE = 1 → PCSrcE = 1 one cycle after Decode. With ZeroE = 0 → PCSrcE = 0. jal → PCSrcE = 1 regardless of ZeroE, and ResultSrcW = 10 three cycles after Decode.
- sw in Decode with FlushE = 1 at the edge → MemWriteM stays 0, PCSrcE = 0, no RegWrite in any stage.
- Illegal: OP = 1111111 → no writes downstream, IllegalOp = 1 next cycle and held (STICKY_ILLEGAL = 1). Assert RESET → IllegalOp = 0 asynchronously.
